// File: rtl/fv_pkg.sv
// rtl/fv_pkg.sv - shared types, FSM encodings and small-operand decoding for the FV multiplier
package fv_pkg;

  localparam int QW_DEF = 5;
  typedef logic [QW_DEF-1:0] coeff_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD    = 2'd0;
  localparam state_t ST_COMPUTE = 2'd1;
  localparam state_t ST_OUTPUT  = 2'd2;

  localparam logic [1:0] U_ZERO = 2'b00;
  localparam logic [1:0] U_POS  = 2'b01;
  localparam logic [1:0] U_NEG  = 2'b11;

  // Returns {is_neg, is_pos}; binary operands can never be negative.
  function automatic logic [1:0] decode_u(input logic [1:0] code, input int uw);
    logic [1:0] s;
    if (uw == 1) s = {1'b0, code[0]};
    else         s = {code == U_NEG, code == U_POS};
    return s;
  endfunction

endpackage

// File: rtl/negacyclic_poly_mult_addsub.sv
// rtl/negacyclic_poly_mult_addsub.sv - combinational a +/- b mod Q for operands already in [0, Q)
module modq_addsub #(
  parameter int QW = 5,
  parameter int Q  = 31
) (
  input  logic [QW-1:0] a_i,
  input  logic [QW-1:0] b_i,
  input  logic          sub_i,
  output logic [QW-1:0] r_o
);

  logic [QW:0] sum;
  logic [QW:0] diff;

  // One conditional correction suffices because both operands are below Q.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    if (sub_i) begin
      r_o = diff[QW] ? QW'(diff + (QW+1)'(Q)) : diff[QW-1:0];
    end else begin
      r_o = (sum >= (QW+1)'(Q)) ? QW'(sum - (QW+1)'(Q)) : sum[QW-1:0];
    end
  end

endmodule

// File: rtl/negacyclic_poly_mult.sv
// rtl/negacyclic_poly_mult.sv - buffered schoolbook negacyclic multiply z = p*u mod (x^N+1) mod Q
module negacyclic_poly_mult
  import fv_pkg::*;
#(
  parameter int N  = 4,
  parameter int QW = 5,
  parameter int Q  = 31,
  parameter int UW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_vld_i,
  input  logic          p_last_i,
  input  logic [QW-1:0] p_data_i,
  output logic          p_rdy_o,
  input  logic          u_vld_i,
  input  logic          u_last_i,
  input  logic [UW-1:0] u_data_i,
  output logic          u_rdy_o,
  output logic          z_vld_o,
  input  logic          z_rdy_i,
  output logic          z_last_o,
  output logic [QW-1:0] z_data_o,
  output logic          busy_o,
  output logic          err_len_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N-1:0][QW-1:0]    pbuf_q, pbuf_d;
  logic [N-1:0][UW-1:0]    ubuf_q, ubuf_d;
  logic [N-1:0][QW-1:0]    acc_q, acc_d;
  logic                    zv_q, zv_d;
  logic                    zl_q, zl_d;
  logic [QW-1:0]           zd_q, zd_d;
  logic                    err_q, err_d;

  logic                    xfer;
  logic                    any_last;
  logic                    frame_end;
  logic                    len_bad;
  logic                    u_illegal;
  logic [QW-1:0]           p_red;
  logic [UW-1:0]           u_st;

  logic [N-1:0]            en_w;
  logic [N-1:0]            sub_w;
  logic [N-1:0][QW-1:0]    res_w;

  // Both streams move together so p_i and u_i always land at the same index.
  assign xfer      = ~rst & (state_q == ST_LOAD) & p_vld_i & u_vld_i;
  assign p_rdy_o   = xfer;
  assign u_rdy_o   = xfer;
  assign any_last  = p_last_i | u_last_i;
  assign frame_end = any_last | (idx_q == IDX_LAST);
  assign len_bad   = (any_last & (idx_q != IDX_LAST)) | (~any_last & (idx_q == IDX_LAST));
  assign u_illegal = (UW == 2) && (2'(u_data_i) == 2'b10);
  assign p_red     = (p_data_i >= QW'(Q)) ? QW'(p_data_i - QW'(Q)) : p_data_i;
  assign u_st      = u_illegal ? UW'(U_ZERO) : u_data_i;

  // Lane k accumulates p_i * u_(k-i mod N); wrapped terms pick up the x^N = -1 sign.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [IW-1:0] j_w;
    logic [1:0]    sgn_w;
    logic          wrap_w;
    assign j_w      = IW'(k) - idx_q;
    assign sgn_w    = decode_u(2'(ubuf_q[j_w]), UW);
    assign wrap_w   = IW'(k) < idx_q;
    assign en_w[k]  = sgn_w[0] | sgn_w[1];
    assign sub_w[k] = wrap_w ? sgn_w[0] : sgn_w[1];
    modq_addsub #(.QW(QW), .Q(Q)) u_addsub (
      .a_i   (acc_q[k]),
      .b_i   (pbuf_q[idx_q]),
      .sub_i (sub_w[k]),
      .r_o   (res_w[k])
    );
  end

  // Next-state logic for the LOAD -> COMPUTE -> OUTPUT frame sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pbuf_d  = pbuf_q;
    ubuf_d  = ubuf_q;
    acc_d   = acc_q;
    zv_d    = zv_q;
    zl_d    = zl_q;
    zd_d    = zd_q;
    err_d   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          pbuf_d[idx_q] = p_red;
          ubuf_d[idx_q] = u_st;
          err_d = u_illegal | (p_last_i ^ u_last_i) | len_bad;
          if (frame_end) begin
            for (int k = 0; k < N; k++) begin
              if (IW'(k) > idx_q) begin
                pbuf_d[k] = '0;
                ubuf_d[k] = '0;
              end
            end
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        for (int k = 0; k < N; k++) begin
          if (en_w[k]) acc_d[k] = res_w[k];
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_OUTPUT;
          zv_d    = 1'b1;
          zd_d    = acc_d[0];
          zl_d    = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_OUTPUT: begin
        if (zv_q & z_rdy_i) begin
          if (idx_q == IDX_LAST) begin
            zv_d    = 1'b0;
            zl_d    = 1'b0;
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + IW'(1);
            zd_d  = acc_q[idx_q + IW'(1)];
            zl_d  = (idx_q + IW'(1)) == IDX_LAST;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
        zv_d    = 1'b0;
        zl_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      pbuf_q  <= '0;
      ubuf_q  <= '0;
      acc_q   <= '0;
      zv_q    <= 1'b0;
      zl_q    <= 1'b0;
      zd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pbuf_q  <= pbuf_d;
      ubuf_q  <= ubuf_d;
      acc_q   <= acc_d;
      zv_q    <= zv_d;
      zl_q    <= zl_d;
      zd_q    <= zd_d;
      err_q   <= err_d;
    end
  end

  assign z_vld_o   = zv_q;
  assign z_last_o  = zl_q;
  assign z_data_o  = zd_q;
  assign busy_o    = (state_q != ST_LOAD);
  assign err_len_o = err_q;

endmodule

// File: tb/tb_negacyclic_poly_mult.sv
// tb/tb_negacyclic_poly_mult.sv - scoreboard bench for negacyclic_poly_mult (binary and ternary u)
module tb_negacyclic_poly_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  logic       a_p_vld, a_p_last, a_p_rdy, a_u_vld, a_u_last, a_u_rdy;
  logic       a_z_vld, a_z_rdy, a_z_last, a_busy, a_err;
  logic [4:0] a_p_data, a_z_data;
  logic [0:0] a_u_data;

  logic       b_p_vld, b_p_last, b_p_rdy, b_u_vld, b_u_last, b_u_rdy;
  logic       b_z_vld, b_z_rdy, b_z_last, b_busy, b_err;
  logic [4:0] b_p_data, b_z_data;
  logic [1:0] b_u_data;

  negacyclic_poly_mult #(.N(4), .QW(5), .Q(31), .UW(1)) dut_a (
    .clk(clk), .rst(rst),
    .p_vld_i(a_p_vld), .p_last_i(a_p_last), .p_data_i(a_p_data), .p_rdy_o(a_p_rdy),
    .u_vld_i(a_u_vld), .u_last_i(a_u_last), .u_data_i(a_u_data), .u_rdy_o(a_u_rdy),
    .z_vld_o(a_z_vld), .z_rdy_i(a_z_rdy), .z_last_o(a_z_last), .z_data_o(a_z_data),
    .busy_o(a_busy), .err_len_o(a_err)
  );

  negacyclic_poly_mult #(.N(4), .QW(5), .Q(31), .UW(2)) dut_b (
    .clk(clk), .rst(rst),
    .p_vld_i(b_p_vld), .p_last_i(b_p_last), .p_data_i(b_p_data), .p_rdy_o(b_p_rdy),
    .u_vld_i(b_u_vld), .u_last_i(b_u_last), .u_data_i(b_u_data), .u_rdy_o(b_u_rdy),
    .z_vld_o(b_z_vld), .z_rdy_i(b_z_rdy), .z_last_o(b_z_last), .z_data_o(b_z_data),
    .busy_o(b_busy), .err_len_o(b_err)
  );

  typedef struct { logic [4:0] d; logic l; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // A-side monitor: scoreboard pops, stall stability, rdy isolation, err pulse count.
  int a_pops = 0, a_errs = 0, a_first_cyc = -1;
  logic a_hold = 1'b0, a_hl, a_vld_prev = 1'b0;
  logic [4:0] a_hd;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (a_err) a_errs++;
      if (a_busy) chk("a_p_rdy_while_busy", a_p_rdy, 0);
      if (a_z_vld && !a_vld_prev && a_first_cyc < 0) a_first_cyc = cyc;
      if (a_hold) begin
        chk("a_stall_data", a_z_data, a_hd);
        chk("a_stall_last", a_z_last, a_hl);
      end
      if (a_z_vld && a_z_rdy) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_beat: got data %0d, expected no beat", a_z_data);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_z_data", a_z_data, e.d);
          chk("a_z_last", a_z_last, e.l);
        end
        a_pops++;
      end
      a_hold = a_z_vld && !a_z_rdy;
      a_hd = a_z_data;
      a_hl = a_z_last;
    end else begin
      a_hold = 1'b0;
    end
    a_vld_prev = a_z_vld;
  end

  // B-side monitor.
  int b_errs = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (b_err) b_errs++;
      if (b_busy) chk("b_p_rdy_while_busy", b_p_rdy, 0);
      if (b_z_vld && b_z_rdy) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_beat: got data %0d, expected no beat", b_z_data);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_z_data", b_z_data, e.d);
          chk("b_z_last", b_z_last, e.l);
        end
      end
    end
  end

  // z ready pattern for A: constant 1, or repeating 1,0,0,1.
  int rdy_mode = 0;
  int ph = 0;
  logic [3:0] pat;
  initial begin
    pat = 4'b1001;
    a_z_rdy = 1'b1;
    b_z_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode != 0) begin a_z_rdy = pat[ph % 4]; ph++; end
      else a_z_rdy = 1'b1;
    end
  end

  task automatic expect_z(input bit sel, input int z[4]);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = 5'(z[i]);
      e.l = (i == 3);
      if (sel == 1'b0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  int last_hs_cyc = 0;
  task automatic send(input bit sel, input int n, input int pv[4], input int uv[4],
                      input bit pl[4], input bit ul[4]);
    for (int i = 0; i < n; i++) begin
      int w;
      bit got;
      if (sel == 1'b0) begin
        a_p_vld = 1; a_u_vld = 1; a_p_data = 5'(pv[i]); a_u_data = 1'(uv[i]);
        a_p_last = pl[i]; a_u_last = ul[i];
      end else begin
        b_p_vld = 1; b_u_vld = 1; b_p_data = 5'(pv[i]); b_u_data = 2'(uv[i]);
        b_p_last = pl[i]; b_u_last = ul[i];
      end
      got = 0;
      for (w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if ((sel == 1'b0) ? (a_p_rdy && a_u_rdy) : (b_p_rdy && b_u_rdy)) begin
          got = 1;
          last_hs_cyc = cyc;
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL input_handshake_timeout: got no rdy, expected rdy within 200 cycles");
      end
      @(posedge clk); #1;
    end
    if (sel == 1'b0) begin a_p_vld = 0; a_u_vld = 0; a_p_last = 0; a_u_last = 0; end
    else begin b_p_vld = 0; b_u_vld = 0; b_p_last = 0; b_u_last = 0; end
  endtask

  task automatic drain(input bit sel);
    int w;
    for (w = 0; w < 300; w++) begin
      @(negedge clk); #2;
      if (((sel == 1'b0) ? qa.size() : qb.size()) == 0) break;
    end
    if (w == 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got outstanding beats, expected queue empty");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int e0;
  initial begin
    rst = 1;
    a_p_vld = 0; a_u_vld = 0; a_p_last = 0; a_u_last = 0; a_p_data = 0; a_u_data = 0;
    b_p_vld = 0; b_u_vld = 0; b_p_last = 0; b_u_last = 0; b_p_data = 0; b_u_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z_vld", a_z_vld, 0);
    chk("rst_z_last", a_z_last, 0);
    chk("rst_z_data", a_z_data, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_err_len", a_err, 0);
    chk("rst_p_rdy", a_p_rdy, 0);
    chk("rst_b_z_vld", b_z_vld, 0);
    rst = 0;
    @(posedge clk); #1;

    // Test 1: binary all-ones u, p has one coefficient equal to Q; latency check.
    e0 = a_errs;
    expect_z(0, '{18, 3, 3, 11});
    send(0, 4, '{30, 8, 31, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    drain(0);
    chk("t1_latency", a_first_cyc - last_hs_cyc, 5);
    chk("t1_err_len", a_errs - e0, 0);

    // Test 2: ternary u = x.
    e0 = b_errs;
    expect_z(1, '{27, 30, 8, 0});
    send(1, 4, '{30, 8, 0, 4}, '{0, 1, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    drain(1);
    chk("t2_err_len", b_errs - e0, 0);

    // Test 3: ternary u = -1.
    e0 = b_errs;
    expect_z(1, '{1, 23, 0, 27});
    send(1, 4, '{30, 8, 0, 4}, '{-1, 0, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    drain(1);
    chk("t3_err_len", b_errs - e0, 0);

    // Illegal ternary code 2'b10 on u_0 is stored as 0, leaving u = x.
    e0 = b_errs;
    expect_z(1, '{27, 30, 8, 0});
    send(1, 4, '{30, 8, 0, 4}, '{2, 1, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    drain(1);
    chk("illegal_u_err_len", b_errs - e0, 1);

    // Test 4: back-pressure 1,0,0,1 with two back-to-back frames.
    e0 = a_errs;
    rdy_mode = 1;
    expect_z(0, '{18, 3, 3, 11});
    expect_z(0, '{18, 3, 3, 11});
    send(0, 4, '{30, 8, 31, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    send(0, 4, '{30, 8, 31, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
    drain(0);
    rdy_mode = 0;
    chk("t4_err_len", a_errs - e0, 0);

    // Test 5: p.last on beat 2 only; (5+6x)(1+x) = 5 + 11x + 6x^2.
    e0 = a_errs;
    expect_z(0, '{5, 11, 6, 0});
    send(0, 2, '{5, 6, 0, 0}, '{1, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0});
    drain(0);
    chk("t5_err_len", a_errs - e0, 1);

    // Full-length frame with no last flag: u = 1 gives z = p.
    e0 = a_errs;
    expect_z(0, '{1, 2, 3, 4});
    send(0, 4, '{1, 2, 3, 4}, '{1, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    drain(0);
    chk("nolast_err_len", a_errs - e0, 1);

    // Test 6: reset after two output beats, then a clean frame.
    begin
      int base, w;
      base = a_pops;
      expect_z(0, '{18, 3, 3, 11});
      send(0, 4, '{30, 8, 31, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
      for (w = 0; w < 100; w++) begin
        @(negedge clk); #2;
        if (a_pops >= base + 2) break;
      end
      if (w == 100) begin
        checks++; errors++;
        $display("FAIL t6_wait_pops: got %0d beats, expected 2", a_pops - base);
      end
      rst = 1;
      #1;
      chk("t6_z_vld_on_rst", a_z_vld, 0);
      chk("t6_busy_on_rst", a_busy, 0);
      qa.delete();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      expect_z(0, '{18, 3, 3, 11});
      send(0, 4, '{30, 8, 31, 4}, '{1, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1});
      drain(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
